can_tx_scheduler: RTL
=====================

CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- MAX_RETRANSMISSIONS, 4, error-terminated attempts allowed per mailbox before it is failed.
- TIMEOUT_CYCLES, 255, maximum cycles in ACTIVE without a transmitter result.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mb_wr  in  4  per-mailbox load strobe.
- wr_id  in  11  message ID to load.
- wr_rtr  in  1  RTR bit to load.
- wr_dlc  in  4  DLC to load.
- wr_data  in  8  data byte to load.
- mb_abort  in  4  per-mailbox abort request.
- bus_idle  in  3  bus-idle history; 3'b111 means 3 recessive bits seen.
- tx_ack  in  1  transmitter success (ACK received).
- tx_arb_lost  in  1  transmitter lost arbitration.
- tx_error  in  1  transmitter error flag.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_id  out  11  ID of the in-flight frame.
- tx_rtr  out  1  RTR of the in-flight frame.
- tx_dlc  out  4  DLC of the in-flight frame.
- tx_data  out  8  data of the in-flight frame.
- tx_busy  out  1  high in WAIT_BUS and ACTIVE.
- cur_mb  out  2  index of the selected mailbox.
- mb_pending  out  4  mailbox holds an unsent frame.
- mb_done  out  4  one-cycle pulse per mailbox on success.
- mb_failed  out  4  one-cycle pulse per mailbox on retry exhaustion, abort or timeout.

Function
REQ-003 Four mailboxes; each stores id, rtr, dlc, data, pending, and a 3-bit retry count.
REQ-004 Loading:
- mb_wr[i] on a mailbox that is not in flight stores all wr_* fields, sets pending, and clears its retry count.
- A load overwrites existing content; pending stays 1.
REQ-005 mb_wr[i] on the in-flight mailbox (cur_mb while tx_busy) is ignored.
REQ-006 FSM states: IDLE, SELECT, WAIT_BUS, ACTIVE. Transitions are registered; one state per cycle.
REQ-007 IDLE -> SELECT when any pending bit is set.
REQ-008 SELECT:
- Winner is the pending mailbox with the numerically lowest id; equal ids resolve to the lowest index.
- Latch cur_mb and tx_id/tx_rtr/tx_dlc/tx_data from the winner.
- If no mailbox is pending (e.g. all aborted), return to IDLE.
- Otherwise go to WAIT_BUS.
REQ-009 WAIT_BUS: when bus_idle == 3'b111, drive tx_start = 1 for exactly the next cycle and enter ACTIVE; otherwise hold.
REQ-010 tx_* outputs stay stable from SELECT exit until ACTIVE exit.
REQ-011 ACTIVE resolution priority, when several are high in the same cycle: tx_error > tx_arb_lost > tx_ack. All outcomes return to IDLE.
REQ-012 On tx_ack: clear pending, pulse mb_done[cur_mb], clear retry count.
REQ-013 On tx_arb_lost: pending stays set and the retry count is unchanged; reselection then lets a newly loaded higher-priority mailbox win.
REQ-014 On tx_error: increment the retry count; if the new count equals MAX_RETRANSMISSIONS, clear pending, pulse mb_failed[cur_mb], and clear the count.
REQ-015 Timeout:
- A timeout counter clears on ACTIVE entry and increments each cycle in ACTIVE.
- Reaching TIMEOUT_CYCLES with no result is treated exactly as tx_error.
REQ-016 Abort of a mailbox not in flight clears pending the same cycle with no pulse.
REQ-017 Abort of the in-flight mailbox is latched:
- A following tx_error or tx_arb_lost fails the mailbox: clear pending, pulse mb_failed.
- A following tx_ack still reports mb_done.
REQ-018 mb_wr[i] and mb_abort[i] in the same cycle: abort wins and the load is discarded.
REQ-019 mb_done and mb_failed are never both high for one mailbox; at most one bit of each vector is high per cycle.

Reset
REQ-020 rst high at a clock edge, including mid-ACTIVE:
- FSM goes to IDLE.
- All pending bits, retry counts, abort latches and the timeout counter clear to 0.
- tx_start, tx_busy, mb_done, mb_failed, mb_pending = 0.
- tx_id, tx_rtr, tx_dlc, tx_data, cur_mb = 0.
REQ-021 No tx_start is issued in the first cycle after rst deasserts.

Verification
REQ-022 Load mb0 id=0x123 and mb2 id=0x050, bus_idle=3'b111 -> tx_start with tx_id=0x050 and cur_mb=2; tx_ack -> mb_done=4'b0100; then mb0 sent.
REQ-023 mb1 and mb3 both id=0x200 -> mb1 is sent first.
REQ-024 mb0 pending, 4 consecutive tx_error -> 4 tx_start pulses, then mb_failed=4'b0001 and mb_pending=0.
REQ-025 mb1 in flight with tx_arb_lost; mb0 loaded with a lower id meanwhile -> the next tx_start carries mb0; mb1 remains pending.
REQ-026 ACTIVE with no response for 255 cycles -> retry count = 1 and a restart on the next bus idle; rst asserted mid-ACTIVE -> all outputs 0 the next cycle.
REQ-027 tx_error and tx_ack in the same cycle -> error path taken and no mb_done; abort plus load of the same mailbox in one cycle -> mailbox not pending.

Source files
------------

// File: rtl/can_tx_scheduler.sv
// Four-mailbox CAN transmit scheduler: lowest-ID arbitration, bus-idle gated start,
// retry/abort/timeout bookkeeping per mailbox.
module can_tx_scheduler #(
    parameter int unsigned MAX_RETRANSMISSIONS = 4,
    parameter int unsigned TIMEOUT_CYCLES      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mb_wr,
    input  logic [10:0] wr_id,
    input  logic        wr_rtr,
    input  logic [3:0]  wr_dlc,
    input  logic [7:0]  wr_data,
    input  logic [3:0]  mb_abort,
    input  logic [2:0]  bus_idle,
    input  logic        tx_ack,
    input  logic        tx_arb_lost,
    input  logic        tx_error,
    output logic        tx_start,
    output logic [10:0] tx_id,
    output logic        tx_rtr,
    output logic [3:0]  tx_dlc,
    output logic [7:0]  tx_data,
    output logic        tx_busy,
    output logic [1:0]  cur_mb,
    output logic [3:0]  mb_pending,
    output logic [3:0]  mb_done,
    output logic [3:0]  mb_failed
);

    localparam int unsigned NMB  = 4;
    localparam int unsigned IDW  = 11;
    localparam int unsigned DLCW = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned RW   = 3;
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SELECT   = 2'd1;
    localparam logic [1:0] S_WAIT_BUS = 2'd2;
    localparam logic [1:0] S_ACTIVE   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  id_q    [NMB];
    logic [IDW-1:0]  id_d    [NMB];
    logic [DLCW-1:0] dlc_q   [NMB];
    logic [DLCW-1:0] dlc_d   [NMB];
    logic [DW-1:0]   data_q  [NMB];
    logic [DW-1:0]   data_d  [NMB];
    logic [RW-1:0]   retry_q [NMB];
    logic [RW-1:0]   retry_d [NMB];
    logic [NMB-1:0]  rtr_q, rtr_d, pend_q, pend_d;
    logic            abort_lat_q, abort_lat_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [1:0]      cur_q, cur_d;
    logic [IDW-1:0]  tx_id_q, tx_id_d;
    logic            tx_rtr_q, tx_rtr_d;
    logic [DLCW-1:0] tx_dlc_q, tx_dlc_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d, busy_q, busy_d;
    logic [NMB-1:0]  done_q, done_d, failed_q, failed_d;

    logic [NMB-1:0]  in_flight;
    logic [NMB-1:0]  sel_cand;
    logic            sel_found;
    logic [1:0]      sel_idx;
    logic [IDW-1:0]  sel_id;
    logic            abort_now, tmo_hit, err_evt;
    logic [RW-1:0]   retry_inc;

    assign in_flight = busy_q ? (NMB'(1) << cur_q) : '0;

    // Lowest ID wins; strict compare keeps the lowest index on ties. Aborted-now mailboxes drop out.
    always_comb begin
        sel_cand  = pend_q & ~mb_abort;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_id    = '0;
        for (int i = 0; i < NMB; i++) begin
            if (sel_cand[i] && (!sel_found || id_q[i] < sel_id)) begin
                sel_found = 1'b1;
                sel_idx   = 2'(i);
                sel_id    = id_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        dlc_d       = dlc_q;
        data_d      = data_q;
        retry_d     = retry_q;
        rtr_d       = rtr_q;
        pend_d      = pend_q;
        abort_lat_d = abort_lat_q;
        tmo_d       = tmo_q;
        cur_d       = cur_q;
        tx_id_d     = tx_id_q;
        tx_rtr_d    = tx_rtr_q;
        tx_dlc_d    = tx_dlc_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        done_d      = '0;
        failed_d    = '0;
        abort_now   = abort_lat_q | mb_abort[cur_q];
        tmo_hit     = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
        err_evt     = tx_error | (tmo_hit & ~tx_arb_lost & ~tx_ack);
        retry_inc   = retry_q[cur_q] + RW'(1);

        // Host side: abort beats load; the in-flight mailbox only latches the abort.
        for (int i = 0; i < NMB; i++) begin
            if (mb_abort[i]) begin
                if (in_flight[i]) abort_lat_d = 1'b1;
                else              pend_d[i]   = 1'b0;
            end else if (mb_wr[i] && !in_flight[i]) begin
                id_d[i]    = wr_id;
                rtr_d[i]   = wr_rtr;
                dlc_d[i]   = wr_dlc;
                data_d[i]  = wr_data;
                pend_d[i]  = 1'b1;
                retry_d[i] = '0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|pend_q) state_d = S_SELECT;
            end
            S_SELECT: begin
                abort_lat_d = 1'b0;
                if (sel_found) begin
                    cur_d     = sel_idx;
                    tx_id_d   = id_q[sel_idx];
                    tx_rtr_d  = rtr_q[sel_idx];
                    tx_dlc_d  = dlc_q[sel_idx];
                    tx_data_d = data_q[sel_idx];
                    state_d   = S_WAIT_BUS;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_WAIT_BUS: begin
                if (bus_idle == 3'b111) begin
                    tx_start_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = S_ACTIVE;
                end
            end
            default: begin
                tmo_d = tmo_q + TW'(1);
                // Error (or timeout) outranks arbitration loss, which outranks ACK.
                if (err_evt) begin
                    if (abort_now || retry_inc == RW'(MAX_RETRANSMISSIONS)) begin
                        pend_d[cur_q]   = 1'b0;
                        failed_d[cur_q] = 1'b1;
                        retry_d[cur_q]  = '0;
                    end else begin
                        retry_d[cur_q]  = retry_inc;
                    end
                    abort_lat_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (tx_arb_lost) begin
                    if (abort_now) begin
                        pend_d[cur_q]   = 1'b0;
                        failed_d[cur_q] = 1'b1;
                        retry_d[cur_q]  = '0;
                    end
                    abort_lat_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (tx_ack) begin
                    pend_d[cur_q]  = 1'b0;
                    done_d[cur_q]  = 1'b1;
                    retry_d[cur_q] = '0;
                    abort_lat_d    = 1'b0;
                    state_d        = S_IDLE;
                end
            end
        endcase

        busy_d = (state_d == S_WAIT_BUS) || (state_d == S_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NMB; i++) begin
                id_q[i]    <= '0;
                dlc_q[i]   <= '0;
                data_q[i]  <= '0;
                retry_q[i] <= '0;
            end
            rtr_q       <= '0;
            pend_q      <= '0;
            abort_lat_q <= 1'b0;
            tmo_q       <= '0;
            cur_q       <= '0;
            tx_id_q     <= '0;
            tx_rtr_q    <= 1'b0;
            tx_dlc_q    <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= '0;
            failed_q    <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            dlc_q       <= dlc_d;
            data_q      <= data_d;
            retry_q     <= retry_d;
            rtr_q       <= rtr_d;
            pend_q      <= pend_d;
            abort_lat_q <= abort_lat_d;
            tmo_q       <= tmo_d;
            cur_q       <= cur_d;
            tx_id_q     <= tx_id_d;
            tx_rtr_q    <= tx_rtr_d;
            tx_dlc_q    <= tx_dlc_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            failed_q    <= failed_d;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_id      = tx_id_q;
    assign tx_rtr     = tx_rtr_q;
    assign tx_dlc     = tx_dlc_q;
    assign tx_data    = tx_data_q;
    assign tx_busy    = busy_q;
    assign cur_mb     = cur_q;
    assign mb_pending = pend_q;
    assign mb_done    = done_q;
    assign mb_failed  = failed_q;

endmodule
